// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: pre-decode slot layout, in-flight
// block metadata and FSM states.
package fetch_sequencer_pkg;

   localparam int SLOT_W       = 54;
   localparam int BLK_W        = 28;
   localparam int TAG_W        = 5;
   localparam int HW_W         = 16;
   localparam int SLOT_VLD_B   = 0;
   localparam int SLOT_TKN_B   = 1;
   localparam int SLOT_TAG_LSB = 2;
   localparam int SLOT_BLK_LSB = 10;
   localparam int SLOT_HW_LSB  = 38;

   typedef enum logic {
      ST_RUN,
      ST_REDIRECT
   } fetch_state_e;

   typedef struct packed {
      logic [BLK_W-1:0] blk;
      logic [2:0]       start_slot;
      logic [2:0]       end_slot;
      logic             taken;
      logic [TAG_W-1:0] tag;
   } fetch_meta_t;

   // Bits [9:7] of a slot are reserved and stay zero.
   function automatic logic [SLOT_W-1:0] pack_slot(input logic             vld,
                                                   input logic             tkn,
                                                   input logic [TAG_W-1:0] tag,
                                                   input logic [BLK_W-1:0] blk,
                                                   input logic [HW_W-1:0]  hw);
      logic [SLOT_W-1:0] s;
      s                           = '0;
      s[SLOT_VLD_B]               = vld;
      s[SLOT_TKN_B]               = tkn;
      s[SLOT_TAG_LSB +: TAG_W]    = tag;
      s[SLOT_BLK_LSB +: BLK_W]    = blk;
      s[SLOT_HW_LSB +: HW_W]      = hw;
      return s;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer (master)
// and instruction memory (slave).
interface fetch_sequencer_if;
   import fetch_sequencer_pkg::*;

   logic             memReq;
   logic [BLK_W-1:0] memAddr;
   logic             memReady;
   logic             memValid;
   logic [127:0]     memData;

   modport master (output memReq, memAddr, input memReady, memValid, memData);
   modport slave  (input memReq, memAddr, output memReady, memValid, memData);

endinterface

// File: rtl/fetch_sequencer_meta_fifo.sv
// Small FIFO holding per-request block metadata until the in-order memory
// response returns; clr_i flushes it on a redirect.
module fetch_meta_fifo
   import fetch_sequencer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        push_i,
   input  fetch_meta_t din_i,
   input  logic        pop_i,
   output fetch_meta_t dout_o,
   output logic        empty_o,
   output logic        full_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   fetch_meta_t   mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign dout_o  = mem_q[rd_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
      if (push_ok) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
      if (pop_ok)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
      if (clr_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, issues 16-byte block requests, applies
// predictor/backend redirects and packs responses for pre-decode.
// Optional perf counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int          NUM_SLOTS    = 8,
   parameter int          MAX_INFLIGHT = 2,
   parameter logic [30:0] RESET_PC     = 31'h0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        IN_mispred,
   input  logic [30:0]                 IN_mispredPC,
   output logic [30:0]                 OUT_bpPC,
   input  logic                        IN_bpTaken,
   input  logic [2:0]                  IN_bpSrcSlot,
   input  logic [30:0]                 IN_bpDst,
   input  logic [TAG_W-1:0]            IN_bpTag,
   fetch_sequencer_if.master           mem,
   input  logic                        IN_pdFull,
   output logic                        OUT_ifetchValid,
   output logic [NUM_SLOTS*SLOT_W-1:0] OUT_instrs
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                 OUT_stallFullCnt,
   output logic [31:0]                 OUT_squashCnt,
   output logic [31:0]                 OUT_blockCnt
`endif
);

   localparam int IW = $clog2(MAX_INFLIGHT + 1);

   fetch_state_e               state_q, state_d;
   logic [30:0]                pc_q, pc_d;
   logic [IW-1:0]              inflight_q, inflight_d, drop_q, drop_d;
   logic                       vld_q, vld_d;
   logic [NUM_SLOTS*SLOT_W-1:0] instrs_q, instrs_d;
   logic                       req, accept, resp, drop, pop, tkn, clr;
   logic                       fifo_empty, fifo_full;
   fetch_meta_t                meta_in, meta_out;

   // Responses with nothing outstanding (e.g. stale after reset) are ignored.
   assign req    = (state_q == ST_RUN) && !IN_pdFull && (inflight_q < IW'(MAX_INFLIGHT))
                   && !fifo_full && !IN_mispred && !rst;
   assign accept = req && mem.memReady;
   assign resp   = mem.memValid && (inflight_q != '0);
   assign drop   = resp && (drop_q != '0);
   assign pop    = resp && !drop && !fifo_empty;
   assign tkn    = IN_bpTaken && (IN_bpSrcSlot >= pc_q[2:0]);

   assign meta_in = '{blk:        pc_q[30:3],
                      start_slot: pc_q[2:0],
                      end_slot:   tkn ? IN_bpSrcSlot : 3'd7,
                      taken:      tkn,
                      tag:        IN_bpTag};

   assign mem.memReq      = req;
   assign mem.memAddr     = pc_q[30:3];
   assign OUT_bpPC        = pc_q;
   assign OUT_ifetchValid = vld_q;
   assign OUT_instrs      = instrs_q;

   fetch_meta_fifo #(.DEPTH(MAX_INFLIGHT)) u_meta_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr),
      .push_i  (accept),
      .din_i   (meta_in),
      .pop_i   (pop),
      .dout_o  (meta_out),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   always_comb begin
      state_d    = ST_RUN;
      pc_d       = pc_q;
      inflight_d = inflight_q + IW'(accept) - IW'(resp);
      drop_d     = drop_q - IW'(drop);
      vld_d      = pop;
      clr        = 1'b0;
      if (accept) pc_d = tkn ? IN_bpDst : {pc_q[30:3] + 28'd1, 3'b000};
      // Everything still outstanding after this cycle's accounting gets squashed.
      if (IN_mispred) begin
         pc_d    = IN_mispredPC;
         drop_d  = inflight_d;
         clr     = 1'b1;
         vld_d   = 1'b0;
         state_d = ST_REDIRECT;
      end
   end

   always_comb begin
      instrs_d = instrs_q;
      if (pop) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            instrs_d[i*SLOT_W +: SLOT_W] = pack_slot(
               (3'(i) >= meta_out.start_slot) && (3'(i) <= meta_out.end_slot),
               meta_out.taken && (3'(i) == meta_out.end_slot),
               meta_out.tag, meta_out.blk, mem.memData[i*HW_W +: HW_W]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         vld_q      <= 1'b0;
         instrs_q   <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         vld_q      <= vld_d;
         instrs_q   <= instrs_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_q, squash_q, block_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q  <= '0;
         squash_q <= '0;
         block_q  <= '0;
      end else begin
         stall_q  <= sat_inc(stall_q, (state_q == ST_RUN) && IN_pdFull && !IN_mispred);
         squash_q <= sat_inc(squash_q, drop);
         block_q  <= sat_inc(block_q, vld_q);
      end
   end

   assign OUT_stallFullCnt = stall_q;
   assign OUT_squashCnt    = squash_q;
   assign OUT_blockCnt     = block_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end controller that sequences instruction fetch into the pre-decode buffer.
- Owns the fetch PC, issues 16-byte block requests to instruction memory, and applies branch-predictor redirects.
- Packs returned blocks into the 8-slot, 54-bit-per-slot pre-decode input format.
- Throttles on pre-decode full, and squashes in-flight fetches on mispredict.

Parameters:
- NUM_SLOTS, 8, halfword slots per fetch block (fixed at 8 by slot encoding).
- MAX_INFLIGHT, 2, maximum outstanding memory requests; power of two.
- RESET_PC, 31'h0, halfword address loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- IN_mispred  in  1  redirect from backend
- IN_mispredPC  in  31  halfword redirect target
- OUT_bpPC  out  31  current fetch PC to predictor (combinational lookup)
- IN_bpTaken  in  1  predicted-taken branch in current block
- IN_bpSrcSlot  in  3  slot of predicted branch
- IN_bpDst  in  31  predicted target, halfword address
- IN_bpTag  in  5  predictor tag forwarded to pre-decode
- OUT_memReq  out  1  fetch request valid
- OUT_memAddr  out  28  block address (PC[30:3])
- IN_memReady  in  1  memory accepts request
- IN_memValid  in  1  in-order response valid
- IN_memData  in  128  eight halfwords, slot 0 in bits [15:0]
- IN_pdFull  in  1  pre-decode buffer full
- OUT_ifetchValid  out  1  block valid to pre-decode
- OUT_instrs  out  NUM_SLOTS*54  packed slots

Behaviour:
- Slot layout (per slot i, base i*54):
  - [0] valid
  - [1] predicted-taken
  - [6:2] bpTag
  - [37:10] block address
  - [53:38] instruction halfword
  - all other bits 0
- Reset values:
  - PC = RESET_PC
  - inflight = 0, dropCnt = 0
  - state = RUN
  - OUT_memReq = 0, OUT_ifetchValid = 0, OUT_instrs = 0
- FSM has two states, RUN and REDIRECT.
- RUN:
  - OUT_memReq = !IN_pdFull && inflight < MAX_INFLIGHT && !IN_mispred.
  - Request accept = memReq && memReady.
  - On accept, push a meta FIFO (depth MAX_INFLIGHT) entry {startSlot = PC[2:0], endSlot, taken, tag}.
  - endSlot and taken: if IN_bpTaken && IN_bpSrcSlot >= PC[2:0], then endSlot = IN_bpSrcSlot and taken = 1; otherwise endSlot = 7 and taken = 0.
  - Next PC on accept: taken ? IN_bpDst : {PC[30:3]+1, 3'b0}. Block address wraps modulo 2^28.
  - Requests may be retracted; memory must tolerate deassertion without ready.
- IN_mispred, any state, highest priority:
  - PC <= IN_mispredPC.
  - dropCnt <= inflight (after this cycle's accept/response accounting).
  - Meta FIFO cleared.
  - OUT_ifetchValid <= 0.
  - state <= REDIRECT.
- REDIRECT: no request this cycle; return to RUN next cycle.
- Response handling (IN_memValid):
  - If dropCnt > 0: decrement and discard.
  - Otherwise pop meta, and next cycle drive OUT_ifetchValid = 1.
  - Slot i valid iff startSlot <= i <= endSlot.
  - Bit [1] set only on slot endSlot when taken.
  - Tag and block address identical in all slots.
- Latency: response to OUT_ifetchValid is exactly 1 cycle. OUT_ifetchValid is a one-cycle pulse per accepted block.
- inflight counter: +1 on accept, -1 on response; simultaneous accept and response leaves it unchanged. It never exceeds MAX_INFLIGHT and never underflows.
- Integration rule: pre-decode BUF_SIZE >= MAX_INFLIGHT+2, to cover registered-full lag.
- Async reset mid-transfer discards all state. Responses arriving after reset release are ignored: dropCnt is 0 and the meta FIFO is empty, so a pop from empty is suppressed.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs OUT_stallFullCnt[31:0], OUT_squashCnt[31:0] and OUT_blockCnt[31:0]. These count, respectively:
  - cycles the request is blocked by IN_pdFull;
  - dropped responses;
  - delivered blocks.
  Counters saturate and are reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: slot field offsets/widths (54-bit slot, 28-bit block address, 5-bit tag), a packed fetch-meta struct, and the FSM state enum.
- Natural sub-module: fetch_meta_fifo, a MAX_INFLIGHT-deep FIFO with clear input.

Test Plan:
- Reset with RESET_PC = 31'h10, memReady = 1, no prediction -> OUT_memAddr 28'h2 then 28'h3. Each response yields a block with slots 0..7 valid, bit1 = 0.
- PC = 31'h1D, IN_bpTaken = 1, srcSlot = 6, dst = 31'h40 -> block 28'h3 delivered with slots 5..6 valid, taken bit on slot 6. Next OUT_memAddr = 28'h8.
- Hold memValid low with 2 requests accepted -> OUT_memReq deasserts at inflight = 2. One response brings it back next cycle.
- IN_pdFull = 1 -> no request while high. Deassert -> request the following cycle with PC unchanged.
- Two in flight, IN_mispred with PC 31'h80 -> both responses dropped, no OUT_ifetchValid. The next request is at address 28'h10 after the REDIRECT cycle.
- Assert rst asynchronously mid-response -> outputs immediately 0, PC = RESET_PC. A stale response after release produces no output.
